// File: rtl/demux_with_default_reg.sv
// Registered 1-to-HEIGHT demultiplexer with a one-entry holding register, valid/ready
// handshake on both sides, and a saturating count of words dropped for bad select or EN=0.
module demux_with_default_reg #(
    parameter int HEIGHT    = 9,
    parameter int WIDTH     = 32,
    parameter int SEL_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 ASYNCRESETN,
    input  logic [WIDTH-1:0]     I,
    input  logic [SEL_WIDTH-1:0] S,
    input  logic                 EN,
    input  logic                 I_valid,
    output logic                 I_ready,
    output logic [WIDTH-1:0]     O [HEIGHT-1:0],
    output logic [HEIGHT-1:0]    O_valid,
    input  logic [HEIGHT-1:0]    O_ready,
    output logic [CNT_WIDTH-1:0] drop_count
);

    typedef enum logic {EMPTY, FULL} state_t;

    // One extra bit so HEIGHT == 2**SEL_WIDTH still compares correctly.
    localparam logic [SEL_WIDTH:0] HEIGHT_EXT = (SEL_WIDTH+1)'(HEIGHT);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [SEL_WIDTH-1:0] idx_q, idx_d;
    logic [CNT_WIDTH-1:0] drop_q, drop_d;
    logic                 hit;
    logic                 accept;
    logic                 selReady;

    always_comb begin
        O_valid = '0;
        for (int ch = 0; ch < HEIGHT; ch++) begin
            O[ch] = '0;
            if (state_q == FULL && idx_q == SEL_WIDTH'(ch)) begin
                O_valid[ch] = 1'b1;
                O[ch]       = data_q;
            end
        end
    end

    assign selReady   = |(O_valid & O_ready);
    assign I_ready    = ASYNCRESETN && (state_q == EMPTY || selReady);
    assign accept     = I_valid && I_ready;
    assign hit        = EN && ({1'b0, S} < HEIGHT_EXT);
    assign drop_count = drop_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        drop_d  = drop_q;
        if (state_q == FULL && selReady) begin
            state_d = EMPTY;
        end
        if (accept) begin
            if (hit) begin
                state_d = FULL;
                data_d  = I;
                idx_d   = S;
            end else if (drop_q != '1) begin
                drop_d = drop_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q <= EMPTY;
            data_q  <= '0;
            idx_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_demux_with_default_reg.sv
// Scoreboard bench for demux_with_default_reg: stimulus pushes expected deliveries, a
// negedge monitor compares every presented output and pops on handshake.
module tb_demux_with_default_reg;

    localparam int HEIGHT = 9;
    localparam int WIDTH  = 32;
    localparam int SELW   = 8;
    localparam int CNTW   = 4;

    logic             CLK = 1'b0;
    logic             ASYNCRESETN;
    logic [WIDTH-1:0] I;
    logic [SELW-1:0]  S;
    logic             EN;
    logic             I_valid;
    logic             I_ready;
    logic [WIDTH-1:0] O [HEIGHT-1:0];
    logic [HEIGHT-1:0] O_valid;
    logic [HEIGHT-1:0] O_ready;
    logic [CNTW-1:0]  drop_count;

    typedef struct {
        int               ch;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t expQ[$];
    int   testsRun    = 0;
    int   testsFailed = 0;

    demux_with_default_reg #(
        .HEIGHT(HEIGHT), .WIDTH(WIDTH), .SEL_WIDTH(SELW), .CNT_WIDTH(CNTW)
    ) dut (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .I(I), .S(S), .EN(EN),
        .I_valid(I_valid), .I_ready(I_ready), .O(O), .O_valid(O_valid),
        .O_ready(O_ready), .drop_count(drop_count)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        testsRun++;
        if (act !== req) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Present one word and hold it until accepted; the expected delivery is queued on accept.
    task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic [SELW-1:0] s,
                                 input logic en, input logic expHit, output int waits);
        I = d; S = s; EN = en; I_valid = 1'b1;
        waits = 0;
        @(negedge CLK);
        while (!I_ready && waits < 20) begin
            waits++;
            @(negedge CLK);
        end
        if (!I_ready) begin
            checkOutput("accept_timeout", 64'(I_ready), 64'd1);
        end else if (expHit) begin
            expQ.push_back('{int'(s), d});
        end
        @(posedge CLK);
        #1 I_valid = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (ASYNCRESETN) begin
            if (O_valid != '0) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_valid", 64'(O_valid), 64'd0);
                end else begin
                    checkOutput("mon_valid", 64'(O_valid), 64'(1) << expQ[0].ch);
                    checkOutput("mon_data", 64'(O[expQ[0].ch]), 64'(expQ[0].data));
                    for (int k = 0; k < HEIGHT; k++)
                        if (k != expQ[0].ch) checkOutput("mon_default_zero", 64'(O[k]), 64'd0);
                    if (O_ready[expQ[0].ch]) void'(expQ.pop_front());
                end
            end
        end
    end

    initial begin
        int w;
        int totalWaits;
        ASYNCRESETN = 1'b0; I = '0; S = '0; EN = 1'b0; I_valid = 1'b0; O_ready = '1;
        @(posedge CLK);
        @(negedge CLK);
        checkOutput("reset_i_ready", 64'(I_ready), 64'd0);
        checkOutput("reset_o_valid", 64'(O_valid), 64'd0);
        checkOutput("reset_drop", 64'(drop_count), 64'd0);
        checkOutput("reset_o3", 64'(O[3]), 64'd0);
        @(posedge CLK);
        #1 ASYNCRESETN = 1'b1;
        @(negedge CLK);
        checkOutput("post_reset_i_ready", 64'(I_ready), 64'd1);

        @(posedge CLK); #1;
        applyStimulus(32'hA5A5_0001, 8'd3, 1'b1, 1'b1, w);
        @(negedge CLK);
        checkOutput("t1_o_valid", 64'(O_valid), 64'h008);
        checkOutput("t1_o3", 64'(O[3]), 64'hA5A5_0001);
        checkOutput("t1_o4", 64'(O[4]), 64'd0);

        @(posedge CLK); #1;
        totalWaits = 0;
        for (int s = 0; s < HEIGHT; s++) begin
            applyStimulus(32'h1000_0000 + 32'(s), SELW'(s), 1'b1, 1'b1, w);
            totalWaits += w;
        end
        checkOutput("t2_stream_waits", 64'(totalWaits), 64'd0);

        O_ready = 9'h1DF;
        applyStimulus(32'hCAFE_0005, 8'd5, 1'b1, 1'b1, w);
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            checkOutput("t3_stall_i_ready", 64'(I_ready), 64'd0);
            checkOutput("t3_stall_o5", 64'(O[5]), 64'hCAFE_0005);
            checkOutput("t3_stall_valid", 64'(O_valid), 64'h020);
        end
        @(posedge CLK);
        #1 O_ready = '1;
        applyStimulus(32'hBEEF_0001, 8'd1, 1'b1, 1'b1, w);
        checkOutput("t3_same_cycle_accept", 64'(w), 64'd0);

        totalWaits = 0;
        applyStimulus(32'h1, 8'd9,   1'b1, 1'b0, w); totalWaits += w;
        applyStimulus(32'h2, 8'hFF,  1'b1, 1'b0, w); totalWaits += w;
        applyStimulus(32'h3, 8'd2,   1'b0, 1'b0, w); totalWaits += w;
        @(negedge CLK);
        checkOutput("t4_drop3", 64'(drop_count), 64'd3);
        checkOutput("t4_i_ready", 64'(I_ready), 64'd1);
        checkOutput("t4_miss_waits", 64'(totalWaits), 64'd0);

        @(posedge CLK); #1;
        for (int m = 0; m < 20; m++) begin
            applyStimulus(32'h100 + 32'(m), (m == 0) ? 8'h19 : 8'd200, 1'b1, 1'b0, w);
            if (m == 10) begin
                @(negedge CLK);
                checkOutput("t5_drop14", 64'(drop_count), 64'hE);
                @(posedge CLK); #1;
            end
        end
        @(negedge CLK);
        checkOutput("t5_saturated", 64'(drop_count), 64'hF);
        checkOutput("t5_drained", 64'(expQ.size()), 64'd0);

        @(posedge CLK); #1;
        O_ready = '0;
        applyStimulus(32'h7777_0007, 8'd7, 1'b1, 1'b1, w);
        @(negedge CLK);
        checkOutput("t6_full_valid", 64'(O_valid), 64'h080);
        @(posedge CLK);
        #2 ASYNCRESETN = 1'b0;
        #1;
        checkOutput("t6_async_valid", 64'(O_valid), 64'd0);
        checkOutput("t6_async_o7", 64'(O[7]), 64'd0);
        checkOutput("t6_async_drop", 64'(drop_count), 64'd0);
        checkOutput("t6_async_i_ready", 64'(I_ready), 64'd0);
        expQ.delete();
        @(posedge CLK);
        #1 ASYNCRESETN = 1'b1;
        @(negedge CLK);
        checkOutput("t6_release_i_ready", 64'(I_ready), 64'd1);
        checkOutput("t6_release_valid", 64'(O_valid), 64'd0);

        #20;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
